// File: rtl/uart_tx_buf.sv
// Buffered 8N1 UART transmitter: a DEPTH-entry byte FIFO drained back-to-back
// onto tx at BAUD_DIV clocks per bit.
module uart_tx_buf #(
    parameter int BAUD_DIV = 434,
    parameter int DEPTH    = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [7:0]                 wr_data,
    input  logic                       clr_ovf,
    output logic                       tx,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       tx_busy,
    output logic                       ovf
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int BW = $clog2(BAUD_DIV);
    localparam logic [BW-1:0] BAUD_MAX = BW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] OCC_FULL = CW'(DEPTH);
    localparam logic [3:0]    LAST_BIT = 4'd9;

    typedef enum logic {IDLE, TX} state_t;

    state_t        state;
    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] occ;
    logic [9:0]    shreg;
    logic [BW-1:0] baud_cnt;
    logic [3:0]    bit_cnt;
    logic          push, pop, bit_end;

    assign full    = (occ == OCC_FULL);
    assign empty   = (occ == '0);
    assign count   = occ;
    assign tx      = shreg[0];
    assign tx_busy = (state == TX);

    // A write against a full FIFO is dropped even if a pop frees a slot on the same edge.
    assign push    = wr_en && !full;
    assign bit_end = (baud_cnt == BAUD_MAX);
    assign pop     = !empty && ((state == IDLE) || (bit_end && bit_cnt == LAST_BIT));

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      occ <= occ + CW'(1);
            else if (pop && !push) occ <= occ - CW'(1);
            if (wr_en && full) ovf <= 1'b1;
            else if (clr_ovf)  ovf <= 1'b0;
        end
    end

    // Frame is {stop, data, start}; shifting right fills with idle-high 1s.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            shreg    <= '1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        shreg    <= {1'b1, mem[rd_ptr], 1'b0};
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= TX;
                    end
                end
                TX: begin
                    if (!bit_end) begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end else begin
                        baud_cnt <= '0;
                        if (bit_cnt != LAST_BIT) begin
                            shreg   <= {1'b1, shreg[9:1]};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (pop) begin
                            shreg   <= {1'b1, mem[rd_ptr], 1'b0};
                            bit_cnt <= '0;
                        end else begin
                            shreg   <= '1;
                            bit_cnt <= '0;
                            state   <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/uart_tx_buf.md
# uart_tx_buf

Buffered UART transmitter for the SNN design, covering the board-to-host direction of the serial link. It accepts bytes from on-chip logic, such as classification results or echo data, through a write strobe into a DEPTH-entry FIFO. It drains the FIFO onto the tx line as 8N1 frames at a fixed baud rate. Producers need not wait for the line to go idle, and frames go out back-to-back with no gap.

## Interface
- BAUD_DIV, default 434: clocks per bit (50 MHz / 115200); legal range ≥ 2.
- DEPTH, default 8: FIFO entries; power of 2, ≥ 2.
- Reset rst_n, asynchronous, active-low; clock clk.
- clk  input  1  system clock (50 MHz).
- rst_n  input  1  asynchronous active-low reset.
- wr_en  input  1  push wr_data into FIFO this cycle.
- wr_data  input  8  byte to transmit.
- clr_ovf  input  1  synchronous clear of ovf.
- tx  output  1  serial line; idles high.
- full  output  1  FIFO holds DEPTH entries.
- empty  output  1  FIFO holds 0 entries.
- count  output  $clog2(DEPTH+1)  current FIFO occupancy.
- tx_busy  output  1  a frame is in progress (state TX).
- ovf  output  1  sticky flag: a write was dropped because the FIFO was full.

## Operation
- **FIFO.** Circular buffer with read and write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH.
  - count, full and empty are derived from registered occupancy.
- **Write.** On wr_en with full=0 (pre-edge value), wr_data is stored and occupancy increments.
  - On wr_en with full=1, the byte is dropped and ovf is set to 1. This holds even if a pop occurs on the same edge.
- **ovf.** Once set, ovf holds until clr_ovf=1.
  - If clr_ovf and a dropped write land on the same edge, ovf=1 (set wins).
- **Pop.** Occurs only as part of a frame load, described below.
  - Pop and write on the same edge leave occupancy unchanged.
- **Frame format.** 10-bit shift register loaded with {1'b1, data, 1'b0}.
  - tx = shreg[0], so bits go out in the order start(0), d0..d7 (LSB first), stop(1).
  - Shift in 1s on each shift.
- **Counters.** baud_cnt counts 0..BAUD_DIV-1; bit_cnt counts 0..9.
- **FSM states:**
  - IDLE: tx=1. If empty=0, pop the head, load shreg, clear baud_cnt and bit_cnt, and go to TX.
  - TX: baud_cnt increments each cycle. At baud_cnt==BAUD_DIV-1, baud_cnt goes to 0.
    - If bit_cnt<9: shift shreg and increment bit_cnt.
    - If bit_cnt==9 (end of stop bit) and empty=0: pop and load the next frame, stay in TX, bit_cnt=0.
    - If bit_cnt==9 and empty=1: go to IDLE (shreg all 1s).
- **Data stability.** Once loaded, frame data is unaffected by further writes.
- **Reset.** Asynchronous assertion at any time, including mid-frame.
  - The FSM returns to IDLE and the FIFO is flushed (pointers and occupancy 0).
  - The partial frame is abandoned.

## Timing
- **Reset values:**
  - tx=1, full=0, empty=1, count=0, tx_busy=0, ovf=0.
  - shreg all 1s, baud_cnt=0, bit_cnt=0.
- **Flag update.** full, empty, count and ovf change on the edge following the causing write or pop. All outputs are registered or derived from registers.
- **Latency.** A write sampled at edge N into an empty FIFO with the FSM idle:
  - empty falls after N.
  - The load happens at N+1, so tx falls and tx_busy rises after N+1.
  - count returns to 0 after N+1.
- **Bit timing.** Each bit is held exactly BAUD_DIV cycles; a frame lasts 10·BAUD_DIV cycles.
- **Back-to-back.** The stop bit of one frame is followed immediately by the start bit of the next: 0 idle cycles, tx_busy stays 1.
- **Idle return.** After the last frame, tx_busy falls on the same edge that ends the stop bit.
- **Throughput.** One byte per 10·BAUD_DIV cycles.
  - The FIFO absorbs bursts of up to DEPTH bytes while a frame is in flight. That is DEPTH+1 bytes in total counting the byte already loaded.

## Test plan
- **Single byte** (BAUD_DIV=4, DEPTH=8): write 0xA5 to an idle block.
  - tx falls 1 cycle after the write edge.
  - tx shows 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles.
  - tx_busy is high for 40 cycles, then tx=1, empty=1.
- **Burst:** write 0x00, 0xFF, 0x55 on consecutive cycles.
  - Three contiguous frames totalling 120 cycles.
  - tx_busy stays high throughout; count peaks at 2; no idle-high gap between stop and start bits.
- **Overflow:** write 10 bytes 0x01..0x0A on consecutive cycles.
  - 0x01 is loaded, 0x02..0x09 fill the FIFO, and full=1 after the 9th write.
  - 0x0A is dropped and ovf=1.
  - Exactly 9 frames are sent in order.
  - clr_ovf then clears ovf.
- **Simultaneous set/clear:** with full=1, assert wr_en and clr_ovf together → ovf=1 and count stays DEPTH.
- **Mid-frame reset:** assert rst_n=0 at bit 4 of a frame with 3 bytes queued.
  - tx=1 immediately; count=0, empty=1, tx_busy=0.
  - No frames are sent after release until a new write.
- **Default baud:** with BAUD_DIV=434, one byte 0x3C gives a 4340-cycle frame, with bit edges every 434 cycles checked against a reference UART receiver model.
